cr_iu_csr_wr_stage: RTL and testbench

- Write-sequencing stage directly upstream of the gated-clock 32-bit CSR register in the IU.
- Accepts one CSR access request from the decoder via a valid/ready handshake.
- Snapshots the current register value, computes the read-modify-write result (RW/RS/RC), then drives write_data/x_write_en into the register.
- Holds the write while the global clock enable is low, and returns the pre-write value with a done pulse.

---
 rtl/cr_iu_csr_wr_stage_if.sv | 23 ++
 rtl/cr_iu_csr_wr_stage.sv | 118 +++++++++++
 tb/tb_cr_iu_csr_wr_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_iu_csr_wr_stage_if.sv
// Decoder-side request/response bundle of the IU CSR write-sequencing stage.
// The decoder drives the master modport; the write stage uses the slave modport.
interface cr_iu_csr_wr_stage_if #(
   parameter int WIDTH = 32
);
   logic             csr_req_vld;
   logic [1:0]       csr_req_op;
   logic [WIDTH-1:0] csr_req_wdata;
   logic             csr_req_rdy;
   logic             csr_flush;
   logic             csr_done;
   logic [WIDTH-1:0] csr_rd_data;

   modport master (
      output csr_req_vld, csr_req_op, csr_req_wdata, csr_flush,
      input  csr_req_rdy, csr_done, csr_rd_data
   );

   modport slave (
      input  csr_req_vld, csr_req_op, csr_req_wdata, csr_flush,
      output csr_req_rdy, csr_done, csr_rd_data
   );
endinterface

// File: rtl/cr_iu_csr_wr_stage.sv
// CSR write-sequencing stage: snapshots the register, merges the RW/RS/RC operand,
// and issues the write only while the downstream clock gate is enabled.
module cr_iu_csr_wr_stage #(
   parameter int WIDTH = 32
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst,
   input  logic                 cp0_yy_clk_en,
   cr_iu_csr_wr_stage_if.slave  req,
   input  logic [WIDTH-1:0]     x_reg_dout,
   output logic [WIDTH-1:0]     write_data,
   output logic                 x_write_en
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MERGE = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_RW   = 2'b01,
      OP_RS   = 2'b10,
      OP_RC   = 2'b11
   } op_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] old_q, old_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] merged;
   logic             skip_write;
   logic             accept;

   // Read-modify-write merge; a READ re-presents the old value unchanged.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      merged = old_q;
      unique case (op_q)
         OP_RW:   merged = operand_q;
         OP_RS:   merged = old_q | operand_q;
         OP_RC:   merged = old_q & ~operand_q;
         default: merged = old_q;
      endcase
   end

   // Set/clear with an all-zero mask cannot change the register, so the write is elided.
   assign skip_write = (op_q == OP_READ) ||
                       (((op_q == OP_RS) || (op_q == OP_RC)) && (operand_q == '0));

   assign accept = (state_q == IDLE) && req.csr_req_vld && !req.csr_flush;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      operand_d = operand_q;
      old_d     = old_q;
      wdata_d   = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = op_e'(req.csr_req_op);
               operand_d = req.csr_req_wdata;
               old_d     = x_reg_dout;
               state_d   = MERGE;
            end
         end
         MERGE: begin
            if (req.csr_flush) begin
               state_d = IDLE;
            end else begin
               wdata_d = merged;
               state_d = skip_write ? DONE : WRITE;
            end
         end
         WRITE: begin
            if (req.csr_flush) begin
               state_d = IDLE;
            end else if (cp0_yy_clk_en) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      // NOTE: all state, including the data registers, is cleared by the async reset.
      if (cpurst) begin
         state_q   <= IDLE;
         op_q      <= OP_READ;
         operand_q <= '0;
         old_q     <= '0;
         wdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         old_q     <= old_d;
         wdata_q   <= wdata_d;
      end
   end

   // The strobe follows the gate enable directly so a stalled write never leaks through.
   assign x_write_en      = (state_q == WRITE) && cp0_yy_clk_en && !req.csr_flush;
   assign write_data      = wdata_q;
   assign req.csr_req_rdy = (state_q == IDLE);
   assign req.csr_done    = (state_q == DONE);
   assign req.csr_rd_data = old_q;

endmodule

// File: tb/tb_cr_iu_csr_wr_stage.sv
// Directed bench for cr_iu_csr_wr_stage: a transaction-level model sets per-cycle
// expectations and a negedge compare process checks them against the DUT.
module tb_cr_iu_csr_wr_stage;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   localparam int FL_NONE  = 0;
   localparam int FL_MERGE = 1;
   localparam int FL_WRITE = 2;
   localparam int FL_DONE  = 3;

   logic        clk;
   logic        cpurst;
   logic        clk_en;
   logic [31:0] dut_reg;
   logic [31:0] write_data;
   logic        x_write_en;
   logic        preset_en;
   logic [31:0] preset_val;

   cr_iu_csr_wr_stage_if #(.WIDTH(32)) req_if ();

   cr_iu_csr_wr_stage #(.WIDTH(32)) dut (
      .forever_cpuclk (clk),
      .cpurst         (cpurst),
      .cp0_yy_clk_en  (clk_en),
      .req            (req_if),
      .x_reg_dout     (dut_reg),
      .write_data     (write_data),
      .x_write_en     (x_write_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream gated register: loads on the DUT strobe, or a bench preset.
   always @(posedge clk) begin
      if (preset_en)       dut_reg <= preset_val;
      else if (x_write_en) dut_reg <= write_data;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model expectations for the current cycle.
   logic        m_rdy, m_wen, m_done;
   logic [31:0] m_wdata, m_rdata, m_reg;

   always @(negedge clk) begin
      check("rdy",     32'(req_if.csr_req_rdy), 32'(m_rdy));
      check("wen",     32'(x_write_en),         32'(m_wen));
      check("done",    32'(req_if.csr_done),    32'(m_done));
      check("wdata",   write_data,              m_wdata);
      check("rd_data", req_if.csr_rd_data,      m_rdata);
      check("reg",     dut_reg,                 m_reg);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preset(input logic [31:0] v);
      preset_en  = 1'b1;
      preset_val = v;
      step();
      preset_en  = 1'b0;
      m_reg      = v;
   endtask

   // One request from accept to return; leaves the bench in an idle cycle.
   task automatic run_req(input logic [1:0] op, input logic [31:0] wd, input int stall, input int flush_at);
      logic [31:0] old_v, new_v;
      bit          wr;
      old_v = m_reg;
      case (op)
         OP_RW:   new_v = wd;
         OP_RS:   new_v = old_v | wd;
         OP_RC:   new_v = old_v & ~wd;
         default: new_v = old_v;
      endcase
      wr = (op == OP_RW) || ((op != OP_READ) && (wd != 32'h0));
      // accept cycle
      req_if.csr_req_vld   = 1'b1;
      req_if.csr_req_op    = op;
      req_if.csr_req_wdata = wd;
      req_if.csr_flush     = 1'b0;
      clk_en = 1'b1;
      m_rdy = 1'b1; m_wen = 1'b0; m_done = 1'b0;
      step();
      // merge cycle
      req_if.csr_req_vld = 1'b0;
      m_rdy   = 1'b0;
      m_rdata = old_v;
      if (flush_at == FL_MERGE) begin
         req_if.csr_flush = 1'b1;
         step();
         req_if.csr_flush = 1'b0;
         m_rdy = 1'b1;
         return;
      end
      step();
      m_wdata = new_v;
      if (wr) begin
         for (int i = 0; i < stall; i++) begin
            clk_en = 1'b0;
            if (flush_at == FL_WRITE && i == stall - 1) req_if.csr_flush = 1'b1;
            step();
         end
         if (flush_at == FL_WRITE) begin
            req_if.csr_flush = 1'b0;
            clk_en = 1'b1;
            m_rdy  = 1'b1;
            return;
         end
         clk_en = 1'b1;
         m_wen  = 1'b1;
         step();
         m_wen = 1'b0;
         m_reg = new_v;
      end
      // done cycle
      m_done = 1'b1;
      if (flush_at == FL_DONE) req_if.csr_flush = 1'b1;
      step();
      req_if.csr_flush = 1'b0;
      m_done = 1'b0;
      m_rdy  = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cpurst = 1'b1;
      clk_en = 1'b1;
      preset_en = 1'b0;
      preset_val = 32'h0;
      dut_reg = 32'h0;
      req_if.csr_req_vld = 1'b0;
      req_if.csr_req_op = OP_READ;
      req_if.csr_req_wdata = 32'h0;
      req_if.csr_flush = 1'b0;
      m_rdy = 1'b1; m_wen = 1'b0; m_done = 1'b0;
      m_wdata = 32'h0; m_rdata = 32'h0; m_reg = 32'h0;
      step();
      check("reset_rdy",   32'(req_if.csr_req_rdy), 32'h1);
      check("reset_wdata", write_data,              32'h0);
      check("reset_rd",    req_if.csr_rd_data,      32'h0);
      step();
      cpurst = 1'b0;
      step();

      // RW on 0xF0
      preset(32'h0000_00F0);
      run_req(OP_RW, 32'h1234_5678, 0, FL_NONE);
      check("rw_reg", dut_reg,            32'h1234_5678);
      check("rw_rd",  req_if.csr_rd_data, 32'h0000_00F0);

      // RS then RC back to back
      preset(32'h0000_00F0);
      run_req(OP_RS, 32'h0000_000F, 0, FL_NONE);
      check("rs_reg", dut_reg, 32'h0000_00FF);
      run_req(OP_RC, 32'h0000_00F0, 0, FL_NONE);
      check("rc_reg", dut_reg,            32'h0000_000F);
      check("rc_rd",  req_if.csr_rd_data, 32'h0000_00FF);

      // no-write requests; flush in DONE is ignored
      preset(32'hDEAD_BEEF);
      run_req(OP_RS, 32'h0, 0, FL_NONE);
      check("rs0_rd", req_if.csr_rd_data, 32'hDEAD_BEEF);
      run_req(OP_READ, 32'h0000_1234, 0, FL_DONE);
      check("read_rd",  req_if.csr_rd_data, 32'hDEAD_BEEF);
      check("read_reg", dut_reg,            32'hDEAD_BEEF);

      // stalled write
      run_req(OP_RW, 32'hA5A5_A5A5, 5, FL_NONE);
      check("stall_reg", dut_reg, 32'hA5A5_A5A5);

      // flushes in MERGE and in a stalled WRITE
      preset(32'h0000_0055);
      run_req(OP_RW, 32'h0000_0077, 0, FL_MERGE);
      step();
      check("flm_reg", dut_reg, 32'h0000_0055);
      run_req(OP_RW, 32'h0000_0099, 3, FL_WRITE);
      step();
      check("flw_reg",   dut_reg,    32'h0000_0055);
      check("flw_wdata", write_data, 32'h0000_0099);

      // flush in IDLE beats a valid request
      req_if.csr_req_vld = 1'b1;
      req_if.csr_req_op  = OP_RW;
      req_if.csr_req_wdata = 32'h1111_1111;
      req_if.csr_flush   = 1'b1;
      step();
      req_if.csr_req_vld = 1'b0;
      req_if.csr_flush   = 1'b0;
      step();
      check("fli_reg", dut_reg, 32'h0000_0055);

      // reset in a stalled WRITE
      req_if.csr_req_vld = 1'b1;
      req_if.csr_req_op  = OP_RW;
      req_if.csr_req_wdata = 32'hA5A5_A5A5;
      clk_en = 1'b0;
      step();
      req_if.csr_req_vld = 1'b0;
      m_rdy = 1'b0; m_rdata = 32'h0000_0055;
      step();
      m_wdata = 32'hA5A5_A5A5;
      step();
      @(negedge clk);
      #2;
      cpurst = 1'b1;
      clk_en = 1'b1;
      m_rdy = 1'b1; m_wdata = 32'h0; m_rdata = 32'h0;
      #1;
      check("rst_wen",   32'(x_write_en),         32'h0);
      check("rst_rdy",   32'(req_if.csr_req_rdy), 32'h1);
      check("rst_wdata", write_data,              32'h0);
      check("rst_rd",    req_if.csr_rd_data,      32'h0);
      step();
      cpurst = 1'b0;
      step();
      check("rst_reg", dut_reg, 32'h0000_0055);
      run_req(OP_RW, 32'h0BAD_F00D, 0, FL_NONE);
      check("post_reg", dut_reg,            32'h0BAD_F00D);
      check("post_rd",  req_if.csr_rd_data, 32'h0000_0055);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
